// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and clocks-per-bit helper.
// Optional macro UART_TX_PARITY_EN adds the PARITY state to the tx state type.
package uart_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = IDLE,
    S_START  = START,
    S_DATA   = DATA,
    S_PARITY = PARITY,
    S_STOP   = STOP
  } tx_state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE  = IDLE,
    S_START = START,
    S_DATA  = DATA,
    S_STOP  = STOP
  } tx_state_e;
`endif

  // Clock cycles per serial bit for a given clock frequency and baud rate.
  function automatic int unsigned clks_per_bit(input int unsigned clk_fqc,
                                               input int unsigned baud);
    return clk_fqc / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..BAUD_CNT-1 and pulses bit_tick while at BAUD_CNT-1.
// clear holds the count at 0 so the first period after release is a full one.
module uart_baud_gen #(
  parameter int unsigned BAUD_CNT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  localparam int unsigned CNT_W = $clog2(BAUD_CNT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Next count and a registered tick aligned with the last count of the period.
  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    tick_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else begin
      if (cnt_q == CNT_W'(BAUD_CNT - 1)) cnt_d = '0;
      tick_d = (cnt_q == CNT_W'(BAUD_CNT - 2));
    end
  end

  // Counter and tick registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign bit_tick = tick_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 frames, or 8E1/8O1 when UART_TX_PARITY_EN is defined.
// tx, ready and busy are all registered; tx follows the state by one cycle.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned TX_BAUD    = 9600,
  parameter int unsigned CLK_FQC    = 50_000_000,
  parameter int unsigned BAUD_CNT   = clks_per_bit(CLK_FQC, TX_BAUD),
  parameter bit          ODD_PARITY = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  if (BAUD_CNT < 2) begin : g_bad_baud
    $error("uart_tx: BAUD_CNT must be at least 2");
  end
  if (ODD_PARITY > 1'b1) begin : g_bad_parity
    $error("uart_tx: ODD_PARITY must be 0 or 1");
  end

  tx_state_e  state_q, state_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic       tx_q, tx_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       bit_tick;
  logic       baud_clear;
`ifdef UART_TX_PARITY_EN
  logic       parity_q, parity_d;
`endif

  // Timer is held cleared while idle so START gets a full bit period.
  assign baud_clear = (state_q == S_IDLE);

  uart_baud_gen #(
    .BAUD_CNT(BAUD_CNT)
  ) u_baud_gen (
    .clk     (clk),
    .rst     (rst),
    .clear   (baud_clear),
    .bit_tick(bit_tick)
  );

  // Frame sequencing and next value of the serial line.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (valid && ready_q) begin
          state_d   = S_START;
          shift_d   = data;
          bit_idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
          parity_d  = (^data) ^ ODD_PARITY;
`endif
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (bit_tick) state_d = S_DATA;
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (bit_tick) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        tx_d = parity_q;
        if (bit_tick) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        tx_d = 1'b1;
        if (bit_tick) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = !ready_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx    = tx_q;
  assign ready = ready_q;
  assign busy  = busy_q;

endmodule
